// File: rtl/instruction_dispatch_unit_if.sv
// Fetch / operand-read / issue bus between the dispatch unit, the code ROM,
// the data RAM read ports and the execution FSM.
interface instruction_dispatch_unit_if #(
    parameter int OP_W    = 16,
    parameter int DADDR_W = 16,
    parameter int ROM_AW  = 16,
    parameter int ROW_W   = 96
);
    logic [ROM_AW-1:0]         oInstructionReadAddress;
    logic [OP_W+3*DADDR_W-1:0] iInstruction;
    logic [DADDR_W-1:0]        oDataReadAddress0;
    logic [DADDR_W-1:0]        oDataReadAddress1;
    logic [ROW_W-1:0]          iDataRead0;
    logic [ROW_W-1:0]          iDataRead1;
    logic                      oDecodeDone;
    logic [OP_W-1:0]           oOperation;
    logic [ROW_W-1:0]          oSource0;
    logic [ROW_W-1:0]          oSource1;
    logic [DADDR_W-1:0]        oDestination;
    logic                      iExeBusy;
    logic                      iResultReady;
    logic                      iJumpFlag;
    logic [ROM_AW-1:0]         iJumpIp;

    modport master (
        output oInstructionReadAddress, oDataReadAddress0, oDataReadAddress1,
               oDecodeDone, oOperation, oSource0, oSource1, oDestination,
        input  iInstruction, iDataRead0, iDataRead1,
               iExeBusy, iResultReady, iJumpFlag, iJumpIp
    );

    modport slave (
        input  oInstructionReadAddress, oDataReadAddress0, oDataReadAddress1,
               oDecodeDone, oOperation, oSource0, oSource1, oDestination,
        output iInstruction, iDataRead0, iDataRead1,
               iExeBusy, iResultReady, iJumpFlag, iJumpIp
    );
endinterface

// File: rtl/instruction_dispatch_unit.sv
// Instruction front-end: fetch from code ROM, decode, read two operand rows
// from data RAM, issue with a one-cycle strobe, then advance or branch the IP.

module idu_operand_lane #(
    parameter int ROW_W = 96
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [ROW_W-1:0] rd_row,
    output logic [ROW_W-1:0] row
);
    logic [ROW_W-1:0] row_q;

    always_ff @(posedge Clock) begin
        if (Reset)     row_q <= '0;
        else if (load) row_q <= rd_row;
    end

    // RAM data is only valid in the issue cycle, so it is forwarded while the
    // strobe is high and held from the register afterwards.
    assign row = load ? rd_row : row_q;
endmodule

module instruction_dispatch_unit #(
    parameter int              OP_W      = 16,
    parameter int              DADDR_W   = 16,
    parameter int              ROM_AW    = 16,
    parameter int              ROW_W     = 96,
    parameter logic [OP_W-1:0] RETURN_OP = '0
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        iEnable,
    input  logic [ROM_AW-1:0]           iInitialIp,
    instruction_dispatch_unit_if.master bus,
    output logic [ROM_AW-1:0]           oCurrentIp,
    output logic                        oBusy,
    output logic                        oDone
);
    localparam int NUM_LANES = 2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_READ, S_ISSUE, S_WAIT_EXE
    } state_t;

    state_t                             state_q, state_d;
    logic [ROM_AW-1:0]                  ip_q, ip_d;
    logic [OP_W-1:0]                    op_q, oper_q;
    logic [DADDR_W-1:0]                 dest_q, odest_q;
    logic [NUM_LANES-1:0][DADDR_W-1:0]  src_addr_q;
    logic [NUM_LANES-1:0][ROW_W-1:0]    rd_row, src_row;
    logic                               issue_fire;
    logic                               is_return;

    assign is_return = (op_q == RETURN_OP);

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            ip_q    <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
        end
    end

    // Next-state and IP update
    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        case (state_q)
            S_IDLE: begin
                if (iEnable) begin
                    state_d = S_FETCH;
                    ip_d    = iInitialIp;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_READ;
            S_READ:   state_d = S_ISSUE;
            S_ISSUE: begin
                if (!bus.iExeBusy) state_d = S_WAIT_EXE;
            end
            S_WAIT_EXE: begin
                if (bus.iResultReady) begin
                    if (is_return) begin
                        state_d = S_IDLE;
                    end else if (bus.iJumpFlag) begin
                        state_d = S_FETCH;
                        ip_d    = bus.iJumpIp;
                    end else begin
                        state_d = S_FETCH;
                        ip_d    = ip_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are qualified with Reset so a reset cycle never issues or retires.
    always_comb begin
        oBusy      = (state_q != S_IDLE);
        issue_fire = (state_q == S_ISSUE) && !bus.iExeBusy && !Reset;
        oDone      = (state_q == S_WAIT_EXE) && bus.iResultReady && is_return && !Reset;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            op_q       <= '0;
            dest_q     <= '0;
            src_addr_q <= '0;
            oper_q     <= '0;
            odest_q    <= '0;
        end else begin
            if (state_q == S_DECODE) {op_q, dest_q, src_addr_q} <= bus.iInstruction;
            if (issue_fire) begin
                oper_q  <= op_q;
                odest_q <= dest_q;
            end
        end
    end

    assign rd_row = {bus.iDataRead1, bus.iDataRead0};

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            idu_operand_lane #(.ROW_W(ROW_W)) u_lane (
                .Clock  (Clock),
                .Reset  (Reset),
                .load   (issue_fire),
                .rd_row (rd_row[g]),
                .row    (src_row[g])
            );
        end
    endgenerate

    assign bus.oInstructionReadAddress = ip_q;
    assign bus.oDataReadAddress0       = src_addr_q[0];
    assign bus.oDataReadAddress1       = src_addr_q[1];
    assign bus.oDecodeDone             = issue_fire;
    assign bus.oOperation              = issue_fire ? op_q : oper_q;
    assign bus.oDestination            = issue_fire ? dest_q : odest_q;
    assign bus.oSource0                = src_row[0];
    assign bus.oSource1                = src_row[1];
    assign oCurrentIp                  = ip_q;
endmodule
